// File: rtl/spi_slave_st_fifo.sv
// SPI slave bridging an external master to Avalon-ST source/sink streams,
// with RX/TX FIFOs, configurable word width, SPI mode and bit order.

module spi_slave_st_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign level = wr_ptr - rd_ptr;
endmodule

module spi_slave_st_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          spi_sclk,
  input  logic                          spi_nss,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  output logic                          src_valid,
  output logic [DATA_W-1:0]             src_data,
  input  logic                          src_ready,
  input  logic                          sink_valid,
  input  logic [DATA_W-1:0]             sink_data,
  output logic                          sink_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          rx_overflow,
  output logic                          tx_underrun,
  input  logic                          clr_status
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);
  localparam bit SAMPLE_RISE = ((CPOL ^ CPHA) == 0);

  logic [1:0] rst_pipe;
  logic       rst_n;

  // async assert, sync deassert
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_pipe <= '0;
    else                rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync;
  logic sclk_s, nss_s, mosi_s, sclk_prev, nss_prev;

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{1'(CPOL)}};
      nss_sync  <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'(CPOL);
      nss_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      nss_prev  <= nss_s;
    end
  end
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign nss_s  = nss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_next, tx_head;
  logic nss_fall, nss_rise, sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic word_done, tx_load, tx_pop, tx_push, rx_pop, rx_full, tx_full, tx_empty, rx_empty;
  logic overflow_set, underrun_set;

  always_comb begin
    nss_fall  = nss_prev & ~nss_s;
    nss_rise  = ~nss_prev & nss_s;
    sclk_rise = sclk_s & ~sclk_prev;
    sclk_fall = ~sclk_s & sclk_prev;
    // sclk edges coinciding with the nss fall are ignored; nss fall owns that cycle
    sample_edge = ~nss_s & ~nss_fall & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    shift_edge  = ~nss_s & ~nss_fall & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    rx_next = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s}
                               : {mosi_s, rx_shift[DATA_W-1:1]};
    word_done    = sample_edge & (bit_cnt == LAST);
    tx_load      = (nss_fall & (CPHA == 0)) | (shift_edge & (bit_cnt == '0));
    tx_pop       = tx_load & ~tx_empty;
    underrun_set = tx_load & tx_empty;
    rx_pop       = src_valid & src_ready;
    overflow_set = word_done & rx_full & ~rx_pop;
    tx_push      = sink_valid & sink_ready;
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (nss_rise || nss_fall) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (sample_edge) begin
      rx_shift <= rx_next;
      bit_cnt  <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n)
      tx_shift <= '0;
    else if (tx_load)
      tx_shift <= tx_empty ? '0 : tx_head;
    else if (shift_edge)
      tx_shift <= (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                   : {1'b0, tx_shift[DATA_W-1:1]};
  end

  // set beats clear so an event in the clearing cycle is not lost
  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (overflow_set)    rx_overflow <= 1'b1;
      else if (clr_status) rx_overflow <= 1'b0;
      if (underrun_set)    tx_underrun <= 1'b1;
      else if (clr_status) tx_underrun <= 1'b0;
    end
  end

  spi_slave_st_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk_clk), .rst_n(rst_n), .push(word_done), .din(rx_next), .pop(rx_pop),
    .dout(src_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  spi_slave_st_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk_clk), .rst_n(rst_n), .push(tx_push), .din(sink_data), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  assign src_valid   = ~rx_empty;
  assign sink_ready  = ~tx_full & rst_n;
  assign spi_miso_oe = ~nss_s;
  assign spi_miso    = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
endmodule

// File: tb/tb_spi_slave_st_fifo.sv
// Directed bench: a mode-0 8-bit instance and a mode-3 16-bit LSB-first instance
// sharing sclk/mosi, each with its own nss.
`timescale 1ns/1ps
module tb_spi_slave_st_fifo;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sclk, mosi, nss0, nss1, clr;
  logic miso0, oe0, src_valid0, src_ready0, sink_valid0, sink_ready0, ovf0, unr0;
  logic [7:0] src_data0, sink_data0;
  logic [2:0] rx_level0, tx_level0;
  logic miso1, oe1, src_valid1, src_ready1, sink_valid1, sink_ready1, ovf1, unr1;
  logic [15:0] src_data1, sink_data1;
  logic [2:0] rx_level1, tx_level1;

  spi_slave_st_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .spi_sclk(sclk), .spi_nss(nss0), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .src_valid(src_valid0), .src_data(src_data0),
    .src_ready(src_ready0), .sink_valid(sink_valid0), .sink_data(sink_data0),
    .sink_ready(sink_ready0), .rx_level(rx_level0), .tx_level(tx_level0),
    .rx_overflow(ovf0), .tx_underrun(unr0), .clr_status(clr)
  );

  spi_slave_st_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .spi_sclk(sclk), .spi_nss(nss1), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .src_valid(src_valid1), .src_data(src_data1),
    .src_ready(src_ready1), .sink_valid(sink_valid1), .sink_data(sink_data1),
    .sink_ready(sink_ready1), .rx_level(rx_level1), .tx_level(tx_level1),
    .rx_overflow(ovf1), .tx_underrun(unr1), .clr_status(clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [7:0] d);
    sink_data0 = d; sink_valid0 = 1'b1; ticks(1); sink_valid0 = 1'b0;
  endtask

  task automatic push1(input logic [15:0] d);
    sink_data1 = d; sink_valid1 = 1'b1; ticks(1); sink_valid1 = 1'b0;
  endtask

  task automatic pop0(output logic [7:0] d, output logic v);
    v = src_valid0; d = src_data0; src_ready0 = 1'b1; ticks(1); src_ready0 = 1'b0;
  endtask

  task automatic pop1(output logic [15:0] d, output logic v);
    v = src_valid1; d = src_data1; src_ready1 = 1'b1; ticks(1); src_ready1 = 1'b0;
  endtask

  // mode 0, MSB first: drop nss and clock n bits, leaving sclk high after the last
  task automatic m0_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    nss0 = 1'b0; ticks(HALF);
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i]; ticks(HALF);
      sclk = 1'b1; mi[7-i] = miso0; ticks(HALF);
      if (i < n-1) sclk = 1'b0;
    end
  endtask

  // raise nss before sclk returns idle so no trailing shift edge is seen
  task automatic m0_close();
    nss0 = 1'b1; ticks(HALF); sclk = 1'b0; ticks(HALF);
  endtask

  task automatic m0_frame(input logic [7:0] mo, output logic [7:0] mi);
    m0_bits(mo, 8, mi); m0_close();
  endtask

  // mode 3, LSB first, one 16-bit word inside an open frame
  task automatic m3_word(input logic [15:0] mo, output logic [15:0] mi);
    for (int i = 0; i < 16; i++) begin
      sclk = 1'b0; mosi = mo[i]; ticks(HALF);
      sclk = 1'b1; mi[i] = miso1; ticks(HALF);
    end
  endtask

  typedef struct {
    bit         has_tx;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    bit         exp_unr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  mi, d8;
    logic [15:0] w1, w2, d16;
    logic        v;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'hC3, 8'h00, 8'hC3, 1'b1};

    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; nss0 = 1'b1; nss1 = 1'b1; clr = 1'b0;
    src_ready0 = 1'b0; sink_valid0 = 1'b0; sink_data0 = '0;
    src_ready1 = 1'b0; sink_valid1 = 1'b0; sink_data1 = '0;
    ticks(5); rst_n = 1'b1; ticks(5);

    chk("rst_src_valid", 32'(src_valid0), 32'd0);
    chk("rst_sink_ready", 32'(sink_ready0), 32'd1);
    chk("rst_levels", 32'({rx_level0, tx_level0}), 32'd0);
    chk("rst_flags", 32'({ovf0, unr0}), 32'd0);
    chk("rst_miso_oe", 32'(oe0), 32'd0);
    chk("rst_src_valid1", 32'(src_valid1), 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].has_tx) push0(vecs[i].tx);
      m0_frame(vecs[i].mo, mi);
      ticks(2);
      chk($sformatf("v%0d_miso", i), 32'(mi), 32'(vecs[i].exp_miso));
      chk($sformatf("v%0d_rx_level", i), 32'(rx_level0), 32'd1);
      chk($sformatf("v%0d_rx_data", i), 32'(src_data0), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_underrun", i), 32'(unr0), 32'(vecs[i].exp_unr));
      chk($sformatf("v%0d_overflow", i), 32'(ovf0), 32'd0);
      pop0(d8, v);
      if (vecs[i].exp_unr) begin
        clr = 1'b1; ticks(1); clr = 1'b0; ticks(1);
        chk($sformatf("v%0d_unr_cleared", i), 32'(unr0), 32'd0);
      end
    end

    // mode 3, 16-bit LSB first: two words per frame, second with empty TX
    push1(16'h1234); ticks(2);
    chk("m3_tx_level", 32'(tx_level1), 32'd1);
    sclk = 1'b1; ticks(HALF);
    nss1 = 1'b0; ticks(HALF);
    m3_word(16'hBEEF, w1);
    m3_word(16'h0F0F, w2);
    ticks(HALF); nss1 = 1'b1; ticks(HALF); sclk = 1'b0; ticks(HALF);
    chk("m3_miso_w1", 32'(w1), 32'h1234);
    chk("m3_miso_w2", 32'(w2), 32'h0000);
    chk("m3_rx_level", 32'(rx_level1), 32'd2);
    chk("m3_underrun", 32'(unr1), 32'd1);
    pop1(d16, v);
    chk("m3_rx_w1", 32'({v, d16}), 32'h1BEEF);
    pop1(d16, v);
    chk("m3_rx_w2", 32'({v, d16}), 32'h10F0F);
    chk("m3_rx_empty", 32'(src_valid1), 32'd0);

    // RX overflow: five words into a four-deep FIFO with no reader
    for (int k = 1; k <= 5; k++) m0_frame(8'(k), mi);
    ticks(2);
    chk("ovf_rx_level", 32'(rx_level0), 32'd4);
    chk("ovf_flag", 32'(ovf0), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pop0(d8, v);
      chk($sformatf("ovf_pop%0d", k), 32'({v, d8}), 32'h100 | 32'(k));
    end
    chk("ovf_fifo_drained", 32'(src_valid0), 32'd0);
    clr = 1'b1; ticks(1); clr = 1'b0; ticks(1);
    chk("ovf_cleared", 32'({ovf0, unr0}), 32'd0);

    // aborted partial word then a full one
    m0_bits(8'hFF, 3, mi); m0_close();
    ticks(2);
    chk("abort_no_push", 32'(rx_level0), 32'd0);
    m0_frame(8'h5A, mi);
    ticks(2);
    chk("abort_rx_level", 32'(rx_level0), 32'd1);
    pop0(d8, v);
    chk("abort_rx_data", 32'({v, d8}), 32'h15A);

    // reset mid-word with data in both FIFOs
    push0(8'h11); push0(8'h22); push0(8'h44);
    m0_frame(8'h33, mi);
    chk("pre_rst_miso", 32'(mi), 32'h11);
    m0_bits(8'hC3, 4, mi);
    chk("pre_rst_oe", 32'(oe0), 32'd1);
    chk("pre_rst_levels", 32'({rx_level0, tx_level0}), 32'({3'd1, 3'd1}));
    rst_n = 1'b0; ticks(1);
    chk("in_rst_sink_ready", 32'(sink_ready0), 32'd0);
    chk("in_rst_src_valid", 32'(src_valid0), 32'd0);
    nss0 = 1'b1; sclk = 1'b0; ticks(HALF);
    rst_n = 1'b1; ticks(HALF);
    chk("post_rst_src_valid", 32'(src_valid0), 32'd0);
    chk("post_rst_sink_ready", 32'(sink_ready0), 32'd1);
    chk("post_rst_levels", 32'({rx_level0, tx_level0}), 32'd0);
    chk("post_rst_flags", 32'({ovf0, unr0}), 32'd0);
    push0(8'h96);
    m0_frame(8'h69, mi);
    ticks(2);
    chk("post_rst_miso", 32'(mi), 32'h96);
    chk("post_rst_rx", 32'({rx_level0, src_data0}), 32'({3'd1, 8'h69}));
    chk("post_rst_unr", 32'(unr0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
